// File: rtl/cnt_serializer_pkg.sv
// Shared constants, FSM state type and byte-addressing helper for the
// counter-snapshot serializer.
package psec5_cnt_pkg;

  localparam int NUM_CH       = 8;
  localparam int CNT_W        = 56;
  localparam int BYTES_PER_CH = 7;
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // MSB position of byte k of channel ch; byte 0 holds the counter MSBs.
  function automatic int byte_msb(input int ch, input int k, input int cnt_w);
    return ch * cnt_w + cnt_w - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/cnt_serializer_if.sv
// Channel-select / snapshot request bus and serial result lines of the
// counter serializer.
interface cnt_serializer_if #(
  parameter int NUM_CH = psec5_cnt_pkg::NUM_CH,
  parameter int CNT_W  = psec5_cnt_pkg::CNT_W
);

  logic [NUM_CH-1:0]       load_cnt_ser;
  logic [2:0]              select_reg;
  logic                    inst_readout;
  logic [NUM_CH*CNT_W-1:0] cnt_data;
  logic                    ser_out;
  logic                    busy;
  logic                    byte_done;
  logic                    snap_valid;

  modport master (
    output load_cnt_ser, select_reg, inst_readout, cnt_data,
    input  ser_out, busy, byte_done, snap_valid
  );

  modport slave (
    input  load_cnt_ser, select_reg, inst_readout, cnt_data,
    output ser_out, busy, byte_done, snap_valid
  );

endinterface

// File: rtl/cnt_piso.sv
// 8-bit parallel-in serial-out register, MSB first, with a down-counting
// bit index; byte_done flags the cycle the output carries bit 0.
module cnt_piso (
  input  logic       sclk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       clr_i,
  input  logic       active_i,
  input  logic [7:0] data_i,
  output logic       ser_o,
  output logic       byte_done_o
);

  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (clr_i) begin
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (load_i) begin
      shreg_q   <= data_i;
      bit_cnt_q <= 3'd7;
    end else if (shift_i) begin
      shreg_q   <= {shreg_q[6:0], 1'b0};
      bit_cnt_q <= bit_cnt_q - 3'd1;
    end
  end

  assign ser_o       = shreg_q[7];
  assign byte_done_o = active_i && (bit_cnt_q == 3'd0);

endmodule

// File: rtl/cnt_serializer.sv
// Captures all channel counters on an inst_readout rising edge and shifts the
// byte picked by (load_cnt_ser, select_reg) out MSB first, restarting on change.
module cnt_serializer
  import psec5_cnt_pkg::*;
#(
  parameter int NUM_CH = psec5_cnt_pkg::NUM_CH,
  parameter int CNT_W  = psec5_cnt_pkg::CNT_W
) (
  input logic              sclk,
  input logic              rst,
  cnt_serializer_if.slave  bus
);

  logic [NUM_CH-1:0]       load_prev_q;
  logic [2:0]              sel_prev_q;
  logic                    ro_q;
  logic                    snap_valid_q;
  logic [NUM_CH*CNT_W-1:0] snap_q;
  state_e                  state_q, state_d;

  logic                    sel_valid;
  logic                    load_evt;
  logic                    capture;
  logic [2:0]              sel_idx;
  logic [NUM_CH-1:0][7:0]  ch_byte;
  logic [7:0]              sel_byte;
  logic                    piso_load, piso_shift, piso_clr;
  logic                    piso_ser, piso_done;

  assign sel_valid = $onehot(bus.load_cnt_ser) && (int'(bus.select_reg) < BYTES_PER_CH);
  assign load_evt  = sel_valid &&
                     ((bus.load_cnt_ser != load_prev_q) || (bus.select_reg != sel_prev_q));
  assign capture   = bus.inst_readout && !ro_q;
  // Clamp keeps the part-select in range when select_reg is the "none" code.
  assign sel_idx   = sel_valid ? bus.select_reg : 3'd0;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_byte[gi] = bus.load_cnt_ser[gi]
                         ? snap_q[byte_msb(gi, int'(sel_idx), CNT_W) -: 8]
                         : 8'h00;
    end
  endgenerate

  always_comb begin
    sel_byte = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_byte = sel_byte | ch_byte[c];
    end
  end

  // Loads read snap_q before this edge's capture lands, so a simultaneous
  // snapshot never leaks into the byte being loaded.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_prev_q  <= '0;
      sel_prev_q   <= SEL_NONE;
      ro_q         <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_prev_q <= bus.load_cnt_ser;
      sel_prev_q  <= bus.select_reg;
      ro_q        <= bus.inst_readout;
      if (capture) begin
        snap_q       <= bus.cnt_data;
        snap_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_clr   = 1'b0;
    if (!sel_valid) begin
      state_d  = ST_IDLE;
      piso_clr = 1'b1;
    end else if (load_evt) begin
      state_d   = ST_SHIFT;
      piso_load = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (piso_done) begin
        state_d  = ST_IDLE;
        piso_clr = 1'b1;
      end else begin
        piso_shift = 1'b1;
      end
    end
  end

  cnt_piso u_piso (
    .sclk        (sclk),
    .rst         (rst),
    .load_i      (piso_load),
    .shift_i     (piso_shift),
    .clr_i       (piso_clr),
    .active_i    (state_q == ST_SHIFT),
    .data_i      (sel_byte),
    .ser_o       (piso_ser),
    .byte_done_o (piso_done)
  );

  assign bus.ser_out    = piso_ser;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.byte_done  = piso_done;
  assign bus.snap_valid = snap_valid_q;

endmodule

// File: doc/cnt_serializer.md
CNT_SERIALIZER -- requirements
Module: cnt_serializer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8: number of counter channels (one-hot width of load_cnt_ser).
REQ-002 The block SHALL have parameter CNT_W, default 56: counter width per channel (7 bytes).
REQ-003 sclk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_cnt_ser  input  NUM_CH  one-hot channel select from the SPI block.
REQ-006 select_reg  input  3  byte index within the channel: 0..6 valid, 7 = none.
REQ-007 inst_readout  input  1  snapshot request from the instruction driver.
REQ-008 cnt_data  input  NUM_CH*CNT_W  live counters, channel c at bits [c*CNT_W +: CNT_W].
REQ-009 ser_out  output  1  serialized byte to the SPI serial_out mux, MSB first.
REQ-010 busy  output  1  high while a byte is shifting.
REQ-011 byte_done  output  1  high during the cycle ser_out carries bit 0.
REQ-012 snap_valid  output  1  high once a snapshot has been captured since reset.

Function
REQ-013 Snapshot: on each rising sclk edge where inst_readout is 1 and was 0 on the previous edge, all of cnt_data SHALL be captured into an internal snapshot; snap_valid SHALL be set and held until reset.
REQ-014 A level-held inst_readout SHALL capture exactly once, on its first sampled-high edge.
REQ-015 Selection is valid iff load_cnt_ser has exactly one bit set and select_reg <= 6; byte k of channel c is snapshot bits [c*CNT_W + CNT_W-1-8k -: 8] (byte 0 = counter MSBs).
REQ-016 The block SHALL register the previous (load_cnt_ser, select_reg); a load event occurs on an edge where the current value differs from the registered value and the current value is valid.
REQ-017 States: IDLE, SHIFT; IDLE -> SHIFT on load event; SHIFT -> SHIFT with a 3-bit bit counter; SHIFT -> IDLE after bit 0 unless a load event occurs on that edge.
REQ-018 On a load event, the selected byte SHALL load into the 8-bit shift register and ser_out SHALL present bit 7 after that same edge; bits 6..0 follow on the next 7 edges (latency 0 cycles, 8 cycles per byte).
REQ-019 A load event during SHIFT SHALL abort the current byte and restart at bit 7 of the new byte.
REQ-020 Invalid selection (zero-hot, multi-hot, or select_reg = 7) SHALL force IDLE on the next edge with ser_out = 0, busy = 0.
REQ-021 In IDLE, ser_out SHALL be 0 and byte_done 0.
REQ-022 If a snapshot capture and a load event occur on the same edge, the load SHALL use the pre-capture snapshot contents.
REQ-023 A load event before any snapshot SHALL shift out zeros.

Reset
REQ-024 While rst = 1: state IDLE, snapshot all-zero, shift register 0, bit counter 0, previous selection register = (0, 7), inst_readout edge register 0, ser_out 0, busy 0, byte_done 0, snap_valid 0.
REQ-025 Reset asserted mid-shift SHALL abort immediately and asynchronously; after deassertion, the first valid selection SHALL be treated as a load event.

Structure
REQ-026 A shared package psec5_cnt_pkg SHALL hold NUM_CH, CNT_W, BYTES_PER_CH = 7, SEL_NONE = 3'd7, and the state enum.
REQ-027 The 8-bit parallel-load shift register with its bit counter and byte_done SHALL be a single sub-module, cnt_piso.

Verification
REQ-028 Snapshot with ch2 counter = 56'h0123_4567_89AB_CD; then load_cnt_ser = 8'b0000_0100, select_reg 0..6, each held for 8 edges -> ser_out bytes 01,23,45,67,89,AB,CD, with byte_done on every 8th edge.
REQ-029 Step across all 56 (channel, byte) pairs in the SPI order -> every byte matches the snapshot and busy is never low between bytes.
REQ-030 Change select_reg from 0 to 1 after 3 bits on ch0 -> shifting restarts at bit 7 of byte 1 on that edge, with no extra bits emitted.
REQ-031 load_cnt_ser = 8'b0001_1000, or select_reg = 7 -> ser_out 0 and busy 0 on the next edge.
REQ-032 Hold inst_readout high for 20 edges while cnt_data changes -> the snapshot equals the value on the first high edge, and snap_valid = 1.
REQ-033 Assert rst at bit 4 of a byte -> all outputs 0 immediately; after release, the same selection reloads from bit 7 with zeroed data.
